// File: rtl/ntt_fifo_loader.sv
// ntt_fifo_loader: streams coefficient pairs (k, k+N/2) into a polynomial FIFO slot with modular reduction.
module ntt_fifo_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] Q = DATA_WIDTH'(64'd1152921504606830593)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_dA,
  input  logic [DATA_WIDTH-1:0] in_dB,
  input  logic                  in_last,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [ADDR_WIDTH-1:0] fifo_addrA,
  output logic [ADDR_WIDTH-1:0] fifo_addrB,
  output logic [DATA_WIDTH-1:0] fifo_dA,
  output logic [DATA_WIDTH-1:0] fifo_dB,
  output logic                  fifo_wr_finish,
  output logic                  err_last,
  output logic [15:0]           poly_count
);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t state;
  logic [ADDR_WIDTH-2:0] k;
  logic last_k, accept;
  function automatic logic [DATA_WIDTH-1:0] red(input logic [DATA_WIDTH-1:0] d);
    return (d >= Q) ? d - Q : d;
  endfunction
  always_comb begin
    in_ready = (state == LOAD) ? 1'b1 : (state == IDLE) ? !fifo_full : 1'b0;
    accept = in_valid && in_ready;
    last_k = &k;
  end
  // Upper half of the address space is the k+N/2 partner, so addrB is k with the MSB set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      k <= '0;
      fifo_wr_en <= 1'b0;
      fifo_wr_finish <= 1'b1;
      fifo_addrA <= '0;
      fifo_addrB <= {1'b1, {(ADDR_WIDTH-1){1'b0}}};
      fifo_dA <= '0;
      fifo_dB <= '0;
      err_last <= 1'b0;
      poly_count <= '0;
    end else begin
      fifo_wr_en <= accept;
      if (state == COMMIT) begin
        state <= IDLE;
        k <= '0;
        fifo_wr_finish <= 1'b1;
        poly_count <= poly_count + 16'd1;
      end else if (accept) begin
        state <= last_k ? COMMIT : LOAD;
        k <= k + 1'b1;
        fifo_addrA <= {1'b0, k};
        fifo_addrB <= {1'b1, k};
        fifo_dA <= red(in_dA);
        fifo_dB <= red(in_dB);
        fifo_wr_finish <= 1'b0;
        err_last <= err_last | (in_last ^ last_k);
      end
    end
  end
endmodule

// File: tb/tb_ntt_fifo_loader.sv
// tb_ntt_fifo_loader: directed and random stimulus checked against a beat-counting reference model.
module tb_ntt_fifo_loader;
  localparam int AW = 3;
  localparam int DW = 64;
  localparam logic [63:0] Q = 64'd1152921504606830593;
  logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, in_last = 1'b0, fifo_full = 1'b0;
  logic [DW-1:0] in_dA = '0, in_dB = '0;
  logic in_ready, fifo_wr_en, fifo_wr_finish, err_last;
  logic [AW-1:0] fifo_addrA, fifo_addrB;
  logic [DW-1:0] fifo_dA, fifo_dB;
  logic [15:0] poly_count;
  ntt_fifo_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .Q(Q)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_dA(in_dA), .in_dB(in_dB), .in_last(in_last), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_addrA(fifo_addrA), .fifo_addrB(fifo_addrB),
    .fifo_dA(fifo_dA), .fifo_dB(fifo_dB), .fifo_wr_finish(fifo_wr_finish),
    .err_last(err_last), .poly_count(poly_count)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  int beats = 0;
  bit pend = 0;
  logic e_wr = 0, e_fin = 1, e_err = 0;
  logic [63:0] e_aa = 0, e_ab = 4, e_da = 0, e_db = 0;
  logic [15:0] e_pc = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [63:0] red(input logic [63:0] d);
    return d % Q;
  endfunction
  // One clock: drive at negedge, check in_ready, advance the model at posedge, check outputs.
  task automatic step(input bit r, input bit v, input logic [63:0] a, input logic [63:0] b, input bit l, input bit f);
    bit acc;
    @(negedge clk);
    rstn = r; in_valid = v; in_dA = a; in_dB = b; in_last = l; fifo_full = f;
    #1 chk("in_ready", in_ready, pend ? 0 : (beats > 0 ? 1 : !f));
    acc = v && !pend && (beats > 0 || !f);
    @(posedge clk);
    if (!r) begin
      beats = 0; pend = 0; e_wr = 0; e_fin = 1; e_aa = 0; e_ab = 4; e_da = 0; e_db = 0; e_err = 0; e_pc = 0;
    end else if (pend) begin
      pend = 0; beats = 0; e_wr = 0; e_fin = 1; e_pc = e_pc + 16'd1;
    end else if (acc) begin
      e_wr = 1; e_aa = beats; e_ab = beats + 4; e_da = red(a); e_db = red(b); e_fin = 0;
      if (l != (beats == 3)) e_err = 1;
      if (beats == 3) pend = 1; else beats++;
    end else e_wr = 0;
    #1;
    chk("wr_en", fifo_wr_en, e_wr);
    chk("wr_finish", fifo_wr_finish, e_fin);
    chk("err_last", err_last, e_err);
    chk("poly_count", poly_count, e_pc);
    if (e_wr || !r) begin
      chk("addrA", fifo_addrA, e_aa);
      chk("addrB", fifo_addrB, e_ab);
      chk("dA", fifo_dA, e_da);
      chk("dB", fifo_dB, e_db);
    end
  endtask
  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    @(posedge clk);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_addrB", fifo_addrB, 4);
    chk("rst_finish", fifo_wr_finish, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, i + 1, i + 11, i == 3, 0);
      chk("b2b_addrA", fifo_addrA, i);
      chk("b2b_finish", fifo_wr_finish, 0);
    end
    idle();
    chk("b2b_pc", poly_count, 1);
    chk("b2b_commit", fifo_wr_finish, 1);
    chk("b2b_err", err_last, 0);
    step(1, 1, Q, Q + 5, 0, 0);
    chk("red_q", fifo_dA, 0);
    chk("red_q5", fifo_dB, 5);
    step(1, 1, Q - 1, 3, 0, 0);
    chk("red_qm1", fifo_dA, Q - 1);
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1, 0);
    idle();
    step(1, 1, 7, 7, 0, 1);
    step(1, 1, 7, 7, 0, 1);
    chk("full_no_wr", fifo_wr_en, 0);
    step(1, 1, 20, 30, 0, 0);
    step(1, 1, 21, 31, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 1);
      chk("stall_wr", fifo_wr_en, 0);
    end
    step(1, 1, 22, 32, 0, 1);
    chk("stall_addrA", fifo_addrA, 2);
    chk("stall_addrB", fifo_addrB, 6);
    step(1, 1, 23, 33, 1, 0);
    idle();
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 2, 2, 1, 0);
    chk("err_set", err_last, 1);
    step(1, 1, 3, 3, 0, 0);
    step(1, 1, 4, 4, 1, 0);
    idle();
    idle();
    chk("err_sticky", err_last, 1);
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 2, 2, 0, 0);
    step(1, 1, 3, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("midrst_err", err_last, 0);
    for (int i = 0; i < 4; i++) step(1, 1, i + 5, i + 9, i == 3, 0);
    idle();
    chk("midrst_pc", poly_count, 1);
    for (int c = 0; c < 800; c++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom} % (2 * Q);
      b = ($urandom_range(0, 9) == 0) ? Q : {$urandom, $urandom} % (2 * Q);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, a, b,
           (beats == 3) ^ ($urandom_range(0, 19) == 0), $urandom_range(0, 9) < 3);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ntt_fifo_loader.md
NTT_FIFO_LOADER -- requirements
Module: ntt_fifo_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning log2 of polynomial length N (N = 2^ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning coefficient width.
REQ-003 SHALL have parameter Q, default 1152921504606830593 (2^60-2^14+1), meaning coefficient modulus.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk and rstn.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  synchronous active-low reset.
REQ-007 in_valid  input  1  upstream beat valid.
REQ-008 in_ready  output  1  beat accepted when in_valid && in_ready at rising clk.
REQ-009 in_dA  input  DATA_WIDTH  coefficient k of current polynomial.
REQ-010 in_dB  input  DATA_WIDTH  coefficient k+N/2.
REQ-011 in_last  input  1  upstream marks final beat (k = N/2-1).
REQ-012 fifo_full  input  1  downstream buffer FIFO has no free polynomial slot.
REQ-013 fifo_wr_en  output  1  FIFO writes fifo_dA/fifo_dB at fifo_addrA/fifo_addrB this cycle.
REQ-014 fifo_addrA / fifo_addrB  output  ADDR_WIDTH each  write addresses.
REQ-015 fifo_dA / fifo_dB  output  DATA_WIDTH each  reduced write data.
REQ-016 fifo_wr_finish  output  1  0 while a polynomial is being filled, 1 otherwise; FIFO commits the slot on its 0->1 transition.
REQ-017 err_last  output  1  sticky in_last protocol error.
REQ-018 poly_count  output  16  number of committed polynomials, wraps at 2^16.

Function
REQ-019 SHALL implement states IDLE, LOAD, COMMIT; all FIFO-side outputs registered.
REQ-020 in_ready SHALL be 1 in LOAD, !fifo_full in IDLE, 0 in COMMIT.
REQ-021 An accepted beat with counter k SHALL produce, on the next cycle, fifo_wr_en=1, fifo_addrA=k, fifo_addrB=k+N/2, fifo_dA/fifo_dB = reduced inputs; latency exactly 1 cycle.
REQ-022 Reduction SHALL be a single conditional subtract: out = (d >= Q) ? d-Q : d; inputs >= 2Q are out of contract.
REQ-023 IDLE: accepted beat -> LOAD, counter k=1 after it; fifo_wr_finish goes 0 in the cycle of the first write.
REQ-024 LOAD: in_valid=0 -> fifo_wr_en=0 next cycle, addresses/data hold, counter holds; fifo_full is ignored.
REQ-025 Beat with k = N/2-1 accepted -> COMMIT; fifo_wr_finish stays 0 through that final write cycle and becomes 1 in the following cycle.
REQ-026 COMMIT SHALL last exactly 1 cycle (fifo_wr_finish=1, fifo_wr_en=0), increment poly_count, reset counter to 0, then go to IDLE.
REQ-027 Polynomial boundary SHALL be governed solely by the counter; in_last asserted on k != N/2-1, or deasserted on k = N/2-1, SHALL set err_last on the next cycle; the load continues unaffected.
REQ-028 Counter SHALL wrap from N/2-1 to 0 only via COMMIT; no partial commit.

Reset
REQ-029 While rstn=0 at a rising edge: state IDLE, counter 0, fifo_wr_en=0, fifo_wr_finish=1, fifo_addrA=0, fifo_addrB=N/2, fifo_dA=fifo_dB=0, err_last=0, poly_count=0.
REQ-030 Reset mid-LOAD SHALL discard the partial polynomial; the downstream FIFO shares rstn, so the reset-induced fifo_wr_finish=1 is not a commit.

Verification (ADDR_WIDTH=3, N=8)
REQ-031 Reset: rstn low 2 cycles, fifo_full=0 -> all REQ-029 values, in_ready=1.
REQ-032 Back-to-back: 4 beats dA=1..4, dB=11..14, in_last on 4th -> writes (0,4),(1,5),(2,6),(3,7) on 4 consecutive cycles with fifo_wr_finish=0, then fifo_wr_finish=1, poly_count=1, err_last=0.
REQ-033 Reduction: dA=Q, dB=Q+5 -> fifo_dA=0, fifo_dB=5; dA=Q-1 -> fifo_dA=Q-1.
REQ-034 Backpressure/stall: fifo_full=1 in IDLE -> in_ready=0, no writes; release, send 2 beats, in_valid=0 3 cycles -> fifo_wr_en=0 3 cycles, next write at (2,6).
REQ-035 Protocol error: in_last on beat k=1 -> err_last=1 next cycle, 4 writes still complete, err_last stays 1 until rstn.
REQ-036 Reset mid-load: rstn=0 after beat k=2 -> REQ-029 values; fresh 4-beat load writes from (0,4), poly_count=1.
